// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial front end (states, SPI commands, fusion constants).
// The optional SPI watchdog is enabled by defining INERT_SPI_TIMEOUT_EN.
package inert_pkg;

  typedef enum logic [3:0] {
    S_INIT0,
    S_INIT1,
    S_INIT2,
    S_INIT3,
    S_INIT4,
    S_IDLE,
    S_RD_PRL,
    S_RD_PRH,
    S_RD_AZL,
    S_RD_AZH
  } state_e;

  localparam logic [15:0] CFG_INT = 16'h0D02;
  localparam logic [15:0] CFG_ACC = 16'h1053;
  localparam logic [15:0] CFG_GYR = 16'h1150;
  localparam logic [15:0] CFG_RND = 16'h1460;
  localparam logic [15:0] RD_PRL  = 16'hA200;
  localparam logic [15:0] RD_PRH  = 16'hA300;
  localparam logic [15:0] RD_AZL  = 16'hAC00;
  localparam logic [15:0] RD_AZH  = 16'hAD00;

  localparam logic [15:0] PTCH_RT_OFFSET = 16'h0050;
  localparam logic [15:0] AZ_OFFSET      = 16'h00A0;
  localparam logic [26:0] FUSION_GAIN    = 27'd1024;

  localparam int WDOG_W = 10;

  // States in which an SPI transaction is outstanding and done is expected.
  function automatic logic is_wait(input state_e s);
    return s inside {S_INIT1, S_INIT2, S_INIT3, S_INIT4,
                     S_RD_PRL, S_RD_PRH, S_RD_AZL, S_RD_AZH};
  endfunction

  function automatic logic is_init(input state_e s);
    return s inside {S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_INIT4};
  endfunction

endpackage

// File: rtl/inertial_integrator.sv
// Complementary filter: integrates offset-corrected pitch rate and nudges the
// estimate toward the accelerometer-derived pitch by a fixed gain per sample.
module inertial_integrator
  import inert_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               smpl,
  input  logic        [15:0] ptch_rt,
  input  logic        [15:0] AZ,
  output logic signed [15:0] ptch
);

  logic signed [15:0] rt_c;
  logic signed [15:0] az_c;
  logic signed [25:0] prod;
  logic signed [15:0] p_acc;
  logic        [26:0] fusion;
  logic        [26:0] ptch_int_q;
  logic        [26:0] ptch_int_d;

  always_comb begin
    rt_c   = ptch_rt - PTCH_RT_OFFSET;
    az_c   = AZ - AZ_OFFSET;
    prod   = {{10{az_c[15]}}, az_c} * 26'd327;
    p_acc  = {{3{prod[25]}}, prod[25:13]};
    fusion = (p_acc > ptch) ? FUSION_GAIN : -FUSION_GAIN;
    // Wraps silently in 27 bits; no saturation by design.
    ptch_int_d = ptch_int_q - {{11{rt_c[15]}}, rt_c} + fusion;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_int_q <= '0;
    end else if (smpl) begin
      ptch_int_q <= ptch_int_d;
    end
  end

  assign ptch = ptch_int_q[26:11];

endmodule

// File: rtl/inert_intf.sv
// IMU front end: configures the sensor over SPI, reads pitch rate and Z accel on each
// data-ready, and emits fused samples. Optional SPI watchdog: INERT_SPI_TIMEOUT_EN.
module inert_intf
  import inert_pkg::*;
#(
  parameter bit fast_sim = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch,
  output logic [15:0] ptch_rt,
  output logic        imu_err
);

  state_e      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic        int_ff1_q, int_ff2_q;
  logic [7:0]  prl_q, prl_d, prh_q, prh_d, azl_q, azl_d, azh_q, azh_d;
  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic        smpl_q, smpl_d;
  logic        vld_q;
  logic [15:0] ptch_rt_q;
  logic        tmr_full;
  logic        timeout;
  logic        unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];
  assign tmr_full     = fast_sim ? (&tmr_q[9:0]) : (&tmr_q);

  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    smpl_d  = 1'b0;
    prl_d   = prl_q;
    prh_d   = prh_q;
    azl_d   = azl_q;
    azh_d   = azh_q;
    case (state_q)
      S_INIT0: begin
        tmr_d = tmr_q + 16'd1;
        if (tmr_full) begin
          wrt_d = 1'b1; cmd_d = CFG_INT; state_d = S_INIT1;
        end
      end
      S_INIT1: if (done) begin wrt_d = 1'b1; cmd_d = CFG_ACC; state_d = S_INIT2; end
      S_INIT2: if (done) begin wrt_d = 1'b1; cmd_d = CFG_GYR; state_d = S_INIT3; end
      S_INIT3: if (done) begin wrt_d = 1'b1; cmd_d = CFG_RND; state_d = S_INIT4; end
      S_INIT4: if (done) state_d = S_IDLE;
      S_IDLE: if (int_ff2_q) begin wrt_d = 1'b1; cmd_d = RD_PRL; state_d = S_RD_PRL; end
      S_RD_PRL: if (done) begin
        prl_d = rd_data[7:0]; wrt_d = 1'b1; cmd_d = RD_PRH; state_d = S_RD_PRH;
      end
      S_RD_PRH: if (done) begin
        prh_d = rd_data[7:0]; wrt_d = 1'b1; cmd_d = RD_AZL; state_d = S_RD_AZL;
      end
      S_RD_AZL: if (done) begin
        azl_d = rd_data[7:0]; wrt_d = 1'b1; cmd_d = RD_AZH; state_d = S_RD_AZH;
      end
      S_RD_AZH: if (done) begin
        azh_d = rd_data[7:0]; smpl_d = 1'b1; state_d = S_IDLE;
      end
      default: state_d = S_INIT0;
    endcase
    // A stalled transaction abandons the partial sample; init restarts from scratch.
    if (timeout) begin
      wrt_d   = 1'b0;
      smpl_d  = 1'b0;
      state_d = is_init(state_q) ? S_INIT0 : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT0;
      tmr_q     <= '0;
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
      prl_q     <= '0;
      prh_q     <= '0;
      azl_q     <= '0;
      azh_q     <= '0;
      wrt_q     <= 1'b0;
      cmd_q     <= '0;
      smpl_q    <= 1'b0;
      vld_q     <= 1'b0;
      ptch_rt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
      prl_q     <= prl_d;
      prh_q     <= prh_d;
      azl_q     <= azl_d;
      azh_q     <= azh_d;
      wrt_q     <= wrt_d;
      cmd_q     <= cmd_d;
      smpl_q    <= smpl_d;
      vld_q     <= smpl_q;
      if (smpl_q) ptch_rt_q <= {prh_q, prl_q};
    end
  end

`ifdef INERT_SPI_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q;
  logic              imu_err_q;

  assign timeout = is_wait(state_q) && !done && (wdog_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      imu_err_q <= 1'b0;
    end else begin
      if (wrt_d || !is_wait(state_q)) wdog_q <= '0;
      else if (!done)                 wdog_q <= wdog_q + 1'b1;
      if (timeout) imu_err_q <= 1'b1;
    end
  end

  assign imu_err = imu_err_q;
`else
  assign timeout = 1'b0;
  assign imu_err = 1'b0;
`endif

  inertial_integrator u_integ (
    .clk     (clk),
    .rst_n   (rst_n),
    .smpl    (smpl_q),
    .ptch_rt ({prh_q, prl_q}),
    .AZ      ({azh_q, azl_q}),
    .ptch    (ptch)
  );

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign vld     = vld_q;
  assign ptch_rt = ptch_rt_q;

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf: SPI responder with a command-sequence model and a
// sample-level arithmetic model of the complementary filter.
module tb_inert_intf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = '0;
  logic        wrt, vld, imu_err;
  logic [15:0] cmd, ptch, ptch_rt;

  inert_intf #(.fast_sim(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt), .imu_err(imu_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic [15:0] p;
    logic [15:0] r;
  } samp_t;
  samp_t exp_q[$];

  // Controls owned by the main sequence
  bit         resp_en = 1'b0;
  int         resp_dly = 50;
  bit         withhold = 1'b0;
  logic [7:0] fix_b [16];
  int         fix_cnt = 0;

  // State owned by the responder
  bit          busy = 1'b0;
  bit          err_seen = 1'b0;
  logic [15:0] cur_cmd = '0, last_cmd = '0;
  int          cmd_idx = 0, wrt_cnt = 0, dly_cnt = 0, fix_rd = 0, a300_cyc = 0;
  logic [7:0]  prl = '0, prh = '0, azl = '0;
  longint      m_int = 0;

  // State owned by the compare process
  int          vld_cnt = 0;
  logic [15:0] last_p = '0, last_r = '0;

  function automatic logic [15:0] exp_cmd(input int idx);
    case (idx)
      0: return 16'h0D02;
      1: return 16'h1053;
      2: return 16'h1150;
      3: return 16'h1460;
      default: case ((idx - 4) % 4)
        0: return 16'hA200;
        1: return 16'hA300;
        2: return 16'hAC00;
        default: return 16'hAD00;
      endcase
    endcase
  endfunction

  function automatic longint wrap27(input longint x);
    longint m = 64'sd1 <<< 27;
    longint y = x % m;
    if (y < 0) y += m;
    if (y >= m / 2) y -= m;
    return y;
  endfunction

  // SPI responder plus reference model of commands and fused samples
  always @(negedge clk) begin
    logic [7:0]         b;
    logic signed [15:0] rt_s, az_s;
    int                 rt_c, az_c, prod, p_acc, fusion;
    longint             cur;
    done = 1'b0;
    if (!rst_n) begin
      busy = 1'b0; cmd_idx = 0; wrt_cnt = 0; fix_rd = 0; m_int = 0; err_seen = 1'b0;
    end else begin
      if (imu_err && !err_seen) begin
        err_seen = 1'b1; busy = 1'b0; cmd_idx = 4;
      end
      if (wrt) begin
        chk("wrt_while_busy", busy, 0);
        chk("cmd_seq", cmd, exp_cmd(cmd_idx));
        cmd_idx++; wrt_cnt++;
        last_cmd = cmd; cur_cmd = cmd; busy = 1'b1; dly_cnt = 0;
        if (cmd == 16'hA300) a300_cyc = cyc;
      end else if (busy) begin
        chk("cmd_hold", cmd, cur_cmd);
        if (resp_en && !(withhold && cur_cmd == 16'hA300)) begin
          dly_cnt++;
          if (dly_cnt >= resp_dly) begin
            b = 8'($urandom);
            if (cur_cmd[15] && fix_rd < fix_cnt) begin
              b = fix_b[fix_rd]; fix_rd++;
            end
            rd_data = {8'($urandom), b};
            done = 1'b1; busy = 1'b0;
            case (cur_cmd)
              16'hA200: prl = b;
              16'hA300: prh = b;
              16'hAC00: azl = b;
              16'hAD00: begin
                rt_s   = {prh, prl} - 16'h0050;
                az_s   = {b, azl} - 16'h00A0;
                rt_c   = rt_s;
                az_c   = az_s;
                prod   = az_c * 327;
                p_acc  = prod >>> 13;
                cur    = m_int >>> 11;
                fusion = (p_acc > cur) ? 1024 : -1024;
                m_int  = wrap27(m_int - rt_c + fusion);
                exp_q.push_back('{cyc + 2, 16'(m_int >>> 11), {prh, prl}});
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  // Compare process: vld timing and sample values every cycle
  always @(negedge clk) begin
    bit due;
    if (!rst_n) begin
      exp_q.delete();
      chk("reset_outputs", {wrt, cmd, vld, ptch, ptch_rt, imu_err}, 64'd0);
    end else begin
      due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("vld_timing", vld, due);
      if (due) begin
        chk("ptch", ptch, exp_q[0].p);
        chk("ptch_rt", ptch_rt, exp_q[0].r);
        void'(exp_q.pop_front());
      end
      if (vld) begin
        vld_cnt++; last_p = ptch; last_r = ptch_rt;
        $display("sample %0d: ptch=%h ptch_rt=%h", vld_cnt, ptch, ptch_rt);
      end
`ifndef INERT_SPI_TIMEOUT_EN
      chk("imu_err_tied", imu_err, 0);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_cmd(input logic [15:0] c, input int budget, input string name);
    int start = wrt_cnt;
    int k = 0;
    while (!(wrt_cnt != start && last_cmd == c) && k < budget) begin
      tick(1); k++;
    end
    chk(name, last_cmd, c);
  endtask

  task automatic wait_vld(input int budget, input string name);
    int start = vld_cnt;
    int k = 0;
    while (vld_cnt == start && k < budget) begin
      tick(1); k++;
    end
    chk(name, vld_cnt != start, 1);
  endtask

  task automatic pulse_int();
    INT = 1'b1; tick(3); INT = 1'b0;
  endtask

  initial begin
    int v0;
    int el;
    #1 rst_n = 1'b0;
    tick(3);
    chk("reset_state", {wrt, cmd, vld, ptch, ptch_rt, imu_err}, 64'd0);
    rst_n = 1'b1;

    // No done: exactly one wrt at the end of the init wait
    wait_cmd(16'h0D02, 1200, "init_cmd0");
    chk("first_cmd", cmd, 16'h0D02);
    tick(300);
    chk("single_wrt", wrt_cnt, 1);

    // Answer init with 50-cycle latency; INT raised during INIT2
    fix_b[0] = 8'h34; fix_b[1] = 8'h12; fix_b[2] = 8'hA0; fix_b[3] = 8'h00;
    fix_cnt = 4;
    resp_en = 1'b1;
    wait_cmd(16'h1150, 300, "init_cmd2");
    INT = 1'b1;
    wait_cmd(16'hA200, 400, "first_read");
    INT = 1'b0;
    chk("wrts_before_read", wrt_cnt, 5);
    wait_vld(400, "vld_known");
    chk("ptch_rt_known", last_r, 16'h1234);
    chk("ptch_known", last_p, 16'hFFFD);

    // Random samples with random SPI latency and spacing
    for (int i = 0; i < 12; i++) begin
      resp_dly = $urandom_range(1, 6);
      tick($urandom_range(1, 20));
      pulse_int();
      wait_vld(400, "vld_rand");
    end

    // INT held high: back-to-back samples
    INT = 1'b1;
    for (int i = 0; i < 3; i++) wait_vld(400, "vld_held");
    INT = 1'b0;
    tick(200);

    // Offsets-only input from a clean integrator
    rst_n = 1'b0;
    for (int i = 0; i < 8; i += 4) begin
      fix_b[i] = 8'h50; fix_b[i+1] = 8'h00; fix_b[i+2] = 8'hA0; fix_b[i+3] = 8'h00;
    end
    fix_cnt = 8;
    resp_dly = 3;
    tick(3);
    rst_n = 1'b1;
    wait_cmd(16'h1460, 1300, "reinit_rnd");
    tick(20);
    pulse_int();
    wait_vld(400, "vld_zero1");
    chk("ptch_zero1", last_p, 16'hFFFF);
    chk("ptch_rt_zero1", last_r, 16'h0050);
    pulse_int();
    wait_vld(400, "vld_zero2");

    // Reset in the middle of the AZL read
    v0 = vld_cnt;
    pulse_int();
    wait_cmd(16'hAC00, 200, "reach_azl");
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {wrt, cmd, vld, ptch, ptch_rt, imu_err}, 64'd0);
    tick(3);
    rst_n = 1'b1;
    wait_cmd(16'h0D02, 1200, "restart_init");
    chk("restart_wrt_cnt", wrt_cnt, 1);
    chk("abort_no_vld", vld_cnt, v0);

`ifdef INERT_SPI_TIMEOUT_EN
    // Withhold done for the PRH read
    wait_cmd(16'h1460, 300, "to_init_rnd");
    tick(10);
    withhold = 1'b1;
    pulse_int();
    el = 0;
    while (!imu_err && el < 1200) begin
      tick(1); el++;
    end
    chk("imu_err_set", imu_err, 1);
    el = cyc - a300_cyc;
    chk("timeout_latency", (el >= 1020 && el <= 1030), 1);
    withhold = 1'b0;
    tick(2);
    pulse_int();
    wait_vld(400, "vld_after_timeout");
    chk("imu_err_sticky", imu_err, 1);
`endif

    tick(50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
